// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes and FSM state encodings shared by the memory stage
package mem_stage_pkg;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_e;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: bus transaction watchdog counter with clear, enable and expire flag
module mem_timeout_cnt #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge CLK) cnt_q <= !RST ? '0 : cnt_d;
  assign expire = cnt_q >= CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage performing LW/SW over a req/gnt/rvalid bus with timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        out_valid,
  output logic [31:0] Ins_out,
  output logic [31:0] Wdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  state_e state_q, state_d;
  logic [31:0] ins_out_q, ins_out_d, wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic out_valid_q, out_valid_d, addr_err_q, addr_err_d, bus_err_q, bus_err_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic accept, is_sw, is_mem, misaligned, mem_start, in_req, in_resp;
  logic req_done, resp_done, to_resp, timeout, expire;
  assign in_req     = state_q == S_REQ;
  assign in_resp    = state_q == S_RESP;
  assign accept     = state_q == S_IDLE && in_valid;
  assign is_sw      = Ins[31:26] == OP_SW;
  assign is_mem     = is_sw || Ins[31:26] == OP_LW;
  assign misaligned = Result[1:0] != 2'b00;
  assign mem_start  = accept && is_mem && !misaligned;
  assign req_done   = in_req && mem_gnt && (mem_we_q || mem_rvalid);
  assign to_resp    = in_req && mem_gnt && !mem_we_q && !mem_rvalid;
  assign resp_done  = in_resp && mem_rvalid;
  assign timeout    = expire && ((in_req && !mem_gnt) || (in_resp && !mem_rvalid));
  mem_timeout_cnt #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (mem_start),
    .en     (state_q != S_IDLE),
    .expire (expire)
  );
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      ins_out_q   <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ins_out_q   <= ins_out_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
    end
  end
  always_comb begin
    state_d = mem_start ? S_REQ :
              to_resp ? S_RESP :
              (req_done || resp_done || timeout) ? S_IDLE : state_q;
  end
  always_comb begin
    out_valid_d = (accept && !mem_start) || req_done || resp_done || timeout;
    addr_err_d  = accept && is_mem && misaligned;
    bus_err_d   = timeout;
    ins_out_d   = accept ? Ins : ins_out_q;
    wdata_d     = (accept && !is_mem) ? Result :
                  ((req_done && !mem_we_q) || resp_done) ? mem_rdata :
                  out_valid_d ? '0 : wdata_q;
    mem_req_d   = mem_start ? 1'b1 : ((in_req && mem_gnt) || timeout) ? 1'b0 : mem_req_q;
    mem_addr_d  = mem_start ? Result : mem_addr_q;
    mem_wdata_d = mem_start ? (is_sw ? Rdata2 : '0) : mem_wdata_q;
    mem_we_d    = mem_start ? is_sw : mem_we_q;
  end
  assign in_ready  = state_q == S_IDLE;
  assign out_valid = out_valid_q;
  assign Ins_out   = ins_out_q;
  assign Wdata     = wdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  localparam logic [31:0] I_ADDU = 32'h0043_1021;
  localparam logic [31:0] I_LW   = 32'h8C22_0000;
  localparam logic [31:0] I_SW   = 32'hAC23_0000;
  logic CLK = 1'b0, RST = 1'b0;
  logic in_valid = 1'b0, in_valid_b = 1'b0;
  logic [31:0] Ins = '0, Result = '0, Rdata2 = '0, mem_rdata = '0;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic in_ready, out_valid, addr_err, bus_err, mem_req, mem_we;
  logic [31:0] Ins_out, Wdata, mem_addr, mem_wdata;
  logic b_in_ready, b_out_valid, b_addr_err, b_bus_err, b_mem_req, b_mem_we;
  logic [31:0] b_Ins_out, b_Wdata, b_mem_addr, b_mem_wdata;
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  mem_stage #(.TIMEOUT(16), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .Ins(Ins),
    .Result(Result), .Rdata2(Rdata2), .out_valid(out_valid), .Ins_out(Ins_out),
    .Wdata(Wdata), .addr_err(addr_err), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  mem_stage #(.TIMEOUT(4), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid_b), .in_ready(b_in_ready), .Ins(Ins),
    .Result(Result), .Rdata2(Rdata2), .out_valid(b_out_valid), .Ins_out(b_Ins_out),
    .Wdata(b_Wdata), .addr_err(b_addr_err), .bus_err(b_bus_err), .mem_req(b_mem_req),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (Wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", Wdata); end
    total++; if (Ins_out !== 32'h0) begin bad++; $display("FAIL reset_ins_out got=%h exp=0", Ins_out); end
  endtask
  task automatic test_passthru;
    Ins = I_ADDU; Result = 32'h0000_1234; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_out_valid got=%b exp=1", out_valid); end
    total++; if (Wdata !== 32'h1234) begin bad++; $display("FAIL pass_wdata got=%h exp=00001234", Wdata); end
    total++; if (Ins_out !== I_ADDU) begin bad++; $display("FAIL pass_ins_out got=%h exp=%h", Ins_out, I_ADDU); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready got=%b exp=1", in_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL pass_mem_req got=%b exp=0", mem_req); end
    @(negedge CLK);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_pulse got=%b exp=0", out_valid); end
  endtask
  task automatic test_back_to_back;
    Ins = I_ADDU; Result = 32'hCAFE_0001; in_valid = 1'b1;
    @(negedge CLK);
    Result = 32'hCAFE_0002;
    total++; if (out_valid !== 1'b1 || Wdata !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/cafe0001", out_valid, Wdata); end
    @(negedge CLK);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || Wdata !== 32'hCAFE_0002) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/cafe0002", out_valid, Wdata); end
    @(negedge CLK);
  endtask
  task automatic test_misaligned;
    Ins = I_LW; Result = 32'h0000_0102; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mis_out_valid got=%b exp=1", out_valid); end
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL mis_addr_err got=%b exp=1", addr_err); end
    total++; if (Wdata !== 32'h0) begin bad++; $display("FAIL mis_wdata got=%h exp=0", Wdata); end
    total++; if (Ins_out !== I_LW) begin bad++; $display("FAIL mis_ins_out got=%h exp=%h", Ins_out, I_LW); end
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mis_no_req got=%b/%b exp=0/1", mem_req, in_ready); end
    @(negedge CLK);
    total++; if (addr_err !== 1'b0 || out_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b/%b/%b exp=0/0/0", addr_err, out_valid, mem_req); end
  endtask
  task automatic test_lw;
    Ins = I_LW; Result = 32'h0000_0100; Rdata2 = 32'h1357_9BDF; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL lw_req_c%0d got=%b/%h/%b/%h exp=1/00000100/0/0", i, mem_req, mem_addr, mem_we, mem_wdata); end
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lw_req_stall_c%0d got=%b/%b exp=0/0", i, in_ready, out_valid); end
      mem_gnt = (i == 2);
      @(negedge CLK);
    end
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL lw_resp_c%0d got=%b/%b/%b exp=0/0/0", i, mem_req, in_ready, out_valid); end
      mem_rvalid = (i == 2); mem_rdata = 32'hDEAD_BEEF;
      @(negedge CLK);
    end
    mem_rvalid = 1'b0;
    total++; if (out_valid !== 1'b1 || Wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%b/%h exp=1/deadbeef", out_valid, Wdata); end
    total++; if (in_ready !== 1'b1 || bus_err !== 1'b0 || Ins_out !== I_LW) begin bad++; $display("FAIL lw_done got=%b/%b/%h exp=1/0/%h", in_ready, bus_err, Ins_out, I_LW); end
    @(negedge CLK);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got=%b exp=0", out_valid); end
  endtask
  task automatic test_sw;
    Ins = I_SW; Result = 32'h0000_0200; Rdata2 = 32'hA5A5_A5A5; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sw_req got=%b/%b/%h/%h exp=1/1/00000200/a5a5a5a5", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_gnt = 1'b1;
    @(negedge CLK);
    mem_gnt = 1'b0;
    total++; if (out_valid !== 1'b1 || Wdata !== 32'h0 || Ins_out !== I_SW) begin bad++; $display("FAIL sw_done got=%b/%h/%h exp=1/0/%h", out_valid, Wdata, Ins_out, I_SW); end
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL sw_release got=%b/%b exp=0/1", mem_req, in_ready); end
    @(negedge CLK);
  endtask
  task automatic test_timeout;
    Ins = I_LW; Result = 32'h0000_0300; in_valid_b = 1'b1;
    @(negedge CLK);
    in_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (b_mem_req !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin bad++; $display("FAIL to_wait_c%0d got=%b/%b/%b exp=1/0/0", i, b_mem_req, b_out_valid, b_in_ready); end
      @(negedge CLK);
    end
    total++; if (b_mem_req !== 1'b0 || b_out_valid !== 1'b1 || b_bus_err !== 1'b1) begin bad++; $display("FAIL to_abort got=%b/%b/%b exp=0/1/1", b_mem_req, b_out_valid, b_bus_err); end
    total++; if (b_Wdata !== 32'h0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL to_idle got=%h/%b exp=0/1", b_Wdata, b_in_ready); end
    Ins = I_ADDU; Result = 32'h0000_0055; in_valid_b = 1'b1;
    @(negedge CLK);
    in_valid_b = 1'b0;
    total++; if (b_out_valid !== 1'b1 || b_Wdata !== 32'h55 || b_bus_err !== 1'b0) begin bad++; $display("FAIL to_next got=%b/%h/%b exp=1/00000055/0", b_out_valid, b_Wdata, b_bus_err); end
    @(negedge CLK);
  endtask
  task automatic test_reset_mid;
    Ins = I_LW; Result = 32'h0000_0400; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstreq_pre got=%b exp=1", mem_req); end
    @(negedge CLK);
    RST = 1'b1;
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstreq_drop got=%b/%b exp=0/1", mem_req, in_ready); end
    Ins = I_LW; Result = 32'h0000_0104; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge CLK);
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rstresp_pre got=%b/%b/%b exp=0/0/0", mem_req, in_ready, out_valid); end
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge CLK);
    mem_rvalid = 1'b0;
    total++; if (out_valid !== 1'b0 || Wdata !== 32'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstresp_late got=%b/%h/%b exp=0/0/1", out_valid, Wdata, in_ready); end
    total++; if (Ins_out !== 32'h0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0 || addr_err !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL rstresp_outs got=%h/%h/%b/%h/%b/%b exp=all0", Ins_out, mem_addr, mem_we, mem_wdata, addr_err, bus_err); end
    @(negedge CLK);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstresp_after got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask
  initial begin
    test_reset;
    test_passthru;
    test_back_to_back;
    test_misaligned;
    test_lw;
    test_sw;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX stage.
- Consumes the EX `Result` (ALU value or LW/SW effective address) plus `Rdata2` (store data). Performs LW/SW on the data-memory bus through a req/gnt/rvalid handshake and hands the write-back value to the WB stage.
- Non-memory instructions pass through with one-cycle latency. Memory instructions stall upstream via `in_ready` until the bus transaction completes or times out.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ+RESP before abort (1..65535).
- CNT_W, 16, width of the timeout counter.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous, active-low reset.
- in_valid  input  1  EX presents an instruction this cycle.
- in_ready  output  1  stage can accept; 1 only in IDLE.
- Ins  input  32  instruction from EX.
- Result  input  32  EX result / effective address.
- Rdata2  input  32  store data (rt).
- out_valid  output  1  one-cycle pulse: Wdata/Ins_out valid for WB.
- Ins_out  output  32  registered instruction to WB.
- Wdata  output  32  write-back value (load data or passed Result).
- addr_err  output  1  with out_valid: misaligned LW/SW, no bus access made.
- bus_err  output  1  with out_valid: transaction timed out.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = store.
- mem_addr  output  32  word address (byte address, bits[1:0]=0).
- mem_wdata  output  32  store data.
- mem_gnt  input  1  bus accepted request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read data.

Behaviour:
- Reset: sampled at posedge CLK when RST==0; takes priority over everything.
  - state=IDLE; counter=0.
  - All outputs registered, reset to 0 (in_ready is combinational from state, so it reads 1 after reset).
  - Reset mid-transaction drops mem_req at that edge.
  - A late mem_rvalid arriving after reset is ignored.
- States IDLE, REQ, RESP. `in_ready` = (state==IDLE). in_valid is ignored outside IDLE; upstream holds its values.
- IDLE, in_valid, opcode is neither LW nor SW:
  - Next edge: Wdata<=Result, Ins_out<=Ins, out_valid<=1.
  - Stay in IDLE, so back-to-back accept is allowed.
- IDLE, in_valid, LW/SW with Result[1:0]!=0:
  - Next edge: out_valid=1, addr_err=1, Wdata=0, Ins_out<=Ins.
  - No mem_req is issued.
- IDLE, in_valid, aligned LW/SW:
  - Latch mem_addr<=Result, mem_wdata<=Rdata2 (SW; 0 for LW), mem_we<=(SW), Ins_out<=Ins.
  - Set mem_req<=1, counter<=0, go to REQ.
- REQ:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_gnt.
  - On gnt, mem_req<=0 at that edge.
  - SW on gnt: out_valid<=1, Wdata<=0, go IDLE.
  - LW on gnt with mem_rvalid in the same cycle: capture mem_rdata, out_valid, go IDLE.
  - LW on gnt without rvalid: go RESP.
- RESP: on mem_rvalid, Wdata<=mem_rdata, out_valid<=1, go IDLE.
- Timeout:
  - Counter increments every cycle in REQ/RESP.
  - When counter==TIMEOUT-1 with no completing gnt/rvalid: mem_req<=0, out_valid<=1, bus_err<=1, Wdata<=0, go IDLE.
  - Completion in the same cycle as the timeout wins; no bus_err.
- out_valid, addr_err and bus_err are single-cycle pulses. WB never back-pressures.
- Latency:
  - Non-memory: 1 cycle.
  - SW: 1 + gnt wait.
  - LW: 1 + gnt wait + rvalid wait.
  - Minimum for LW (gnt and rvalid immediate): 2 cycles from accept to out_valid.
- mem_rvalid outside RESP (or outside REQ-with-gnt for LW) is ignored.

Decomposition:
- LW/SW opcodes (6'b100011, 6'b101011) and the state encodings go in the shared common_param header/package alongside the existing opcode constants.
- Sub-module: mem_timeout_cnt (CNT_W counter with clear/enable/expire); everything else stays inline.

Test Plan:
- ADDU pass-through: Ins opcode 0, Result=32'h0000_1234, in_valid 1 cycle → out_valid next cycle, Wdata=32'h1234, in_ready stays 1.
- LW, gnt after 2 cycles, rvalid 3 cycles later, Result=32'h100, rdata=32'hDEAD_BEEF:
  - mem_req held 3 cycles with addr 32'h100, we=0.
  - Wdata=32'hDEADBEEF on out_valid.
  - in_ready low throughout.
- SW, Result=32'h200, Rdata2=32'hA5A5_A5A5, gnt immediate → mem_we=1, wdata=32'hA5A5A5A5; out_valid 1 cycle after gnt; Wdata=0.
- LW with Result=32'h102 → addr_err=1, out_valid=1, mem_req never asserted.
- LW, gnt never arrives, TIMEOUT=4 → mem_req drops, bus_err+out_valid after 4 cycles in REQ; next instruction accepted.
- RST low during RESP, then mem_rvalid → state IDLE, out_valid stays 0, all outputs 0.
